mmio_console: RTL and testbench
===============================

Name: mmio_console

Overview:
- Synthesizable memory-mapped console and exit device on the core's dmem read/write ports, decoded alongside dmem.
- Accepts byte writes to the PUTC address into a FIFO and serializes them on a UART 8N1 TX line.
- Latches a program exit request and code from the EXIT address.
- Exposes a readable status register so firmware can poll FIFO level and transmitter state.

Parameters:
PUTC_ADDR, 32'h9000001c, write-only TX data register (byte lane 0)
STATUS_ADDR, 32'h90000020, read-only status register
EXIT_ADDR, 32'h9000002c, write-only exit register
FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..128
CLK_DIV, 868, clk cycles per UART bit; must be >= 2

Ports:
clk  in  1  clock
resetb  in  1  asynchronous active-low reset
wready  in  1  core write request this cycle
wvalid  out  1  device accepts write; 0 stalls the core
waddr  in  32  write byte address
wdata  in  32  write data
wstrb  in  4  byte enables
rready  in  1  core read request this cycle
rvalid  out  1  read accept; tied 1
raddr  in  32  read byte address
rresp  out  1  read data valid, one cycle after request
rdata  out  32  read data
txd  out  1  UART serial output, idle high
tx_busy  out  1  FIFO non-empty or frame in progress
exit_req  out  1  sticky exit flag
exit_code  out  32  value written to EXIT_ADDR

Behaviour:
- Reset values: txd=1, tx_busy=0, exit_req=0, exit_code=0, rresp=0, rdata=0; FIFO empty; TX FSM in IDLE; baud counter 0.
- Reset is asynchronous and may assert mid-frame: txd returns to 1 immediately, and all FIFO contents are discarded.
- Write decode:
  - push = wready && waddr==PUTC_ADDR && wstrb[0] && !full.
  - wvalid = 0 only when wready && waddr==PUTC_ADDR && wstrb[0] && full; otherwise wvalid = 1 (combinational).
  - Writes to any other address, or PUTC writes with wstrb[0]=0, are acknowledged and ignored.
- full/empty come from the registered count only. A push at full is refused even if a pop happens in the same cycle. Simultaneous push and pop when not full leaves the count unchanged.
- The FIFO read and write pointers are log2(FIFO_DEPTH) bits, wrap naturally, and count is log2(FIFO_DEPTH)+1 bits.
- EXIT:
  - A write with wready && waddr==EXIT_ADDR while exit_req=0 sets exit_req=1 and exit_code=wdata on the next edge.
  - Later EXIT writes are acknowledged but do not change exit_code.
  - PUTC remains operational after exit so the FIFO can drain.
- Read:
  - rresp <= rready each cycle.
  - When rready is high, rdata <= (raddr==STATUS_ADDR) ? status : 0.
  - When rready is low, rdata holds its value.
  - status = {16'h0, count zero-extended to 8 bits, 4'h0, exit_req, tx_busy, empty, full} (full at bit 0).
- TX FSM with states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is not empty, pop the head into the shift register, load the baud counter with CLK_DIV-1, drive txd=0 and go to START. The pop occurs on this edge, so a byte pushed into an empty FIFO starts one cycle after the push edge.
  - START: txd=0 for CLK_DIV cycles, then load the bit index to 0 and go to DATA.
  - DATA: txd=shift[0] for CLK_DIV cycles per bit, LSB first. Shift right after each bit; after bit 7 go to STOP.
  - STOP: txd=1 for CLK_DIV cycles, then return to IDLE. If the FIFO is non-empty there, the next START begins on that same transition edge, so frames are back-to-back with no extra idle cycle.
- Frame length is exactly 10*CLK_DIV cycles.
- tx_busy = !empty || state!=IDLE.

Test Plan:
- Reset with no traffic: txd=1, wvalid=1 for any address, rresp=0, exit_req=0; a status read returns 32'h00000002 one cycle after rready.
- CLK_DIV=4: write 8'h41 to PUTC. txd low for 4 cycles starting one cycle after the push, then 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4; tx_busy falls after 40 cycles.
- FIFO_DEPTH=4, CLK_DIV=4: issue 6 consecutive PUTC writes of 0x30..0x35.
  - First 4 accepted with wvalid=1.
  - After the first pop one more is accepted; the 6th sees wvalid=0 until space frees.
  - txd outputs all six bytes in order with no inter-frame gap.
- Write 32'h0000002a to EXIT, then 32'h1 to EXIT: exit_req=1 and exit_code=32'h2a permanently. A status read then shows bit 3 set.
- Assert resetb low during DATA of a frame with 3 bytes queued: txd=1 immediately; after release status=32'h2, and no further frames are sent.
- Read a non-status address (0x90000024): rdata=0 with rresp one cycle later. A PUTC write with wstrb=4'b0010 is ignored and count stays 0.

Source files
------------

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped putc/status/exit device with a FIFO-fed UART 8N1 transmitter.
// Sits beside dmem on the core's read/write ports; PUTC stalls the core only when the FIFO is full.
module mmio_console #(
   parameter logic [31:0] PUTC_ADDR   = 32'h9000001c,
   parameter logic [31:0] STATUS_ADDR = 32'h90000020,
   parameter logic [31:0] EXIT_ADDR   = 32'h9000002c,
   parameter int          FIFO_DEPTH  = 16,
   parameter int          CLK_DIV     = 868
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        wready,
   output logic        wvalid,
   input  logic [31:0] waddr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        rready,
   output logic        rvalid,
   input  logic [31:0] raddr,
   output logic        rresp,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        tx_busy,
   output logic        exit_req,
   output logic [31:0] exit_code
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        r_state;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_count;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;

   logic        w_full, w_empty, w_putc, w_push, w_pop, w_bdone, w_unused;
   logic [31:0] w_status;

   assign w_full   = r_count == (AW+1)'(FIFO_DEPTH);
   assign w_empty  = r_count == '0;
   assign w_putc   = wready && waddr == PUTC_ADDR && wstrb[0];
   assign w_push   = w_putc && !w_full;
   assign w_bdone  = r_baud == '0;
   // Head is consumed when a frame starts, from IDLE or straight out of STOP.
   assign w_pop    = !w_empty && (r_state == IDLE || (r_state == STOP && w_bdone));
   assign wvalid   = !(w_putc && w_full);
   assign rvalid   = 1'b1;
   assign tx_busy  = !w_empty || r_state != IDLE;
   assign w_status = {16'h0, 8'(r_count), 4'h0, exit_req, tx_busy, w_empty, w_full};
   assign w_unused = ^wstrb[3:1];

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= wdata[7:0];

   always_ff @(posedge clk or negedge resetb)
      if (!resetb) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end

   always_ff @(posedge clk or negedge resetb)
      if (!resetb) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         txd     <= 1'b1;
      end else begin
         case (r_state)
            IDLE:
               if (!w_empty) begin
                  r_shift <= r_mem[r_rp];
                  r_baud  <= BAUD_MAX;
                  txd     <= 1'b0;
                  r_state <= START;
               end
            START:
               if (w_bdone) begin
                  r_baud  <= BAUD_MAX;
                  r_bit   <= '0;
                  txd     <= r_shift[0];
                  r_state <= DATA;
               end else r_baud <= r_baud - BW'(1);
            DATA:
               if (w_bdone) begin
                  r_baud  <= BAUD_MAX;
                  r_bit   <= r_bit + 3'd1;
                  r_shift <= r_shift >> 1;
                  txd     <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
                  r_state <= (r_bit == 3'd7) ? STOP : DATA;
               end else r_baud <= r_baud - BW'(1);
            STOP:
               if (w_bdone) begin
                  if (!w_empty) begin
                     r_shift <= r_mem[r_rp];
                     r_baud  <= BAUD_MAX;
                     txd     <= 1'b0;
                     r_state <= START;
                  end else r_state <= IDLE;
               end else r_baud <= r_baud - BW'(1);
         endcase
      end

   always_ff @(posedge clk or negedge resetb)
      if (!resetb) begin
         rresp     <= 1'b0;
         rdata     <= '0;
         exit_req  <= 1'b0;
         exit_code <= '0;
      end else begin
         rresp <= rready;
         if (rready) rdata <= (raddr == STATUS_ADDR) ? w_status : '0;
         // First exit write wins; the code is frozen from then on.
         if (wready && waddr == EXIT_ADDR && !exit_req) begin
            exit_req  <= 1'b1;
            exit_code <= wdata;
         end
      end
endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: register-access vector table plus UART receiver scoreboard for mmio_console.
// Built with FIFO_DEPTH=4, CLK_DIV=4 so full-FIFO stalls and frame timing stay short.
module tb_mmio_console;
   localparam logic [31:0] PUTC  = 32'h9000001c;
   localparam logic [31:0] STAT  = 32'h90000020;
   localparam logic [31:0] EXITA = 32'h9000002c;

   logic        clk = 0, resetb = 0, wready = 0, rready = 0;
   logic [31:0] waddr = 0, wdata = 0, raddr = 0;
   logic [3:0]  wstrb = 0;
   logic        wvalid, rvalid, rresp, txd, tx_busy, exit_req;
   logic [31:0] rdata, exit_code;

   mmio_console #(.FIFO_DEPTH(4), .CLK_DIV(4)) dut (
      .clk(clk), .resetb(resetb), .wready(wready), .wvalid(wvalid), .waddr(waddr),
      .wdata(wdata), .wstrb(wstrb), .rready(rready), .rvalid(rvalid), .raddr(raddr),
      .rresp(rresp), .rdata(rdata), .txd(txd), .tx_busy(tx_busy),
      .exit_req(exit_req), .exit_code(exit_code)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0, cyc = 0, frames = 0;
   logic [7:0] exp_q[$];
   int starts[$];

   always_ff @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // UART receiver: samples once per cycle on the falling edge, mid-bit after the start edge.
   initial begin
      int m = 0;
      bit act = 0;
      logic [7:0] b = 0;
      forever begin
         @(negedge clk);
         if (!resetb) act = 0;
         else if (!act) begin
            if (txd === 1'b0) begin
               act = 1;
               m = 0;
               starts.push_back(cyc);
               frames++;
            end
         end else begin
            m++;
            if (m >= 5 && m <= 33 && (m - 5) % 4 == 0) b[3'((m - 5) / 4)] = txd;
            if (m == 37) begin
               act = 0;
               check("stop_bit", 32'(txd), 32'd1);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_frame: got %h expected none", b);
               end else check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   typedef struct {
      logic wr; logic [31:0] wa, wd; logic [3:0] ws;
      logic rd; logic [31:0] ra;
      logic e_wv, e_rresp; logic [31:0] e_rdata; logic e_exit; logic [31:0] e_code;
   } vec_t;
   vec_t tbl[10];

   function automatic logic exp_txd(input logic [7:0] b, input int j);
      int k;
      if (j == 0) return 1'b1;
      k = (j - 1) / 4;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[3'(k - 1)];
      return 1'b1;
   endfunction

   task automatic idle_bus();
      wready = 0; rready = 0; waddr = 0; wdata = 0; wstrb = 0; raddr = 0;
   endtask

   task automatic put(input logic [7:0] b);
      wready = 1; waddr = PUTC; wdata = {24'h0, b}; wstrb = 4'h1;
   endtask

   initial begin
      logic [31:0] addrs[4];
      int nb, nf, lows, stall, guard;
      logic [7:0] bytes6[6];
      tbl[0] = '{0, 32'h0,        32'h0,        4'h0, 1, STAT,         1, 1, 32'h2,  0, 32'h0};
      tbl[1] = '{1, 32'h00001000, 32'h12345678, 4'hf, 0, 32'h0,        1, 0, 32'h2,  0, 32'h0};
      tbl[2] = '{0, 32'h0,        32'h0,        4'h0, 1, 32'h90000024, 1, 1, 32'h0,  0, 32'h0};
      tbl[3] = '{1, PUTC,         32'h41,       4'h2, 0, 32'h0,        1, 0, 32'h0,  0, 32'h0};
      tbl[4] = '{0, 32'h0,        32'h0,        4'h0, 1, STAT,         1, 1, 32'h2,  0, 32'h0};
      tbl[5] = '{1, EXITA,        32'h2a,       4'hf, 0, 32'h0,        1, 0, 32'h2,  1, 32'h2a};
      tbl[6] = '{1, EXITA,        32'h1,        4'hf, 0, 32'h0,        1, 0, 32'h2,  1, 32'h2a};
      tbl[7] = '{0, 32'h0,        32'h0,        4'h0, 1, STAT,         1, 1, 32'ha,  1, 32'h2a};
      tbl[8] = '{1, EXITA,        32'h5,        4'hf, 1, PUTC,         1, 1, 32'h0,  1, 32'h2a};
      tbl[9] = '{0, 32'h0,        32'h0,        4'h0, 1, STAT,         1, 1, 32'ha,  1, 32'h2a};
      addrs = '{PUTC, STAT, EXITA, 32'h0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_txd", 32'(txd), 1);
      check("rst_busy", 32'(tx_busy), 0);
      resetb = 1;
      foreach (addrs[i]) begin
         wready = 1; waddr = addrs[i]; wstrb = 4'hf;
         #1 check("rst_wvalid", 32'(wvalid), 1);
      end
      idle_bus();
      check("rst_rresp", 32'(rresp), 0);
      check("rst_rdata", rdata, 0);
      check("rst_exit", 32'(exit_req), 0);
      check("rst_code", exit_code, 0);
      check("rvalid", 32'(rvalid), 1);

      // Register-access table
      @(negedge clk);
      foreach (tbl[i]) begin
         wready = tbl[i].wr; waddr = tbl[i].wa; wdata = tbl[i].wd; wstrb = tbl[i].ws;
         rready = tbl[i].rd; raddr = tbl[i].ra;
         #1 check("tbl_wvalid", 32'(wvalid), 32'(tbl[i].e_wv));
         @(posedge clk);
         @(negedge clk);
         idle_bus();
         check("tbl_rresp", 32'(rresp), 32'(tbl[i].e_rresp));
         check("tbl_rdata", rdata, tbl[i].e_rdata);
         check("tbl_exit", 32'(exit_req), 32'(tbl[i].e_exit));
         check("tbl_code", exit_code, tbl[i].e_code);
      end
      check("ignored_busy", 32'(tx_busy), 0);

      // Single byte 0x41: exact waveform and busy timing
      @(negedge clk);
      exp_q.push_back(8'h41);
      put(8'h41);
      #1 check("putc_wvalid", 32'(wvalid), 1);
      @(posedge clk);
      #1 idle_bus();
      for (int j = 0; j <= 41; j++) begin
         @(negedge clk);
         check($sformatf("txd_%0d", j), 32'(txd), 32'(exp_txd(8'h41, j)));
         check($sformatf("busy_%0d", j), 32'(tx_busy), 32'(j <= 40));
      end

      // Six back-to-back writes into a 4-deep FIFO
      bytes6 = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      nb = starts.size();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         put(bytes6[i]);
         exp_q.push_back(bytes6[i]);
         #1 check($sformatf("burst_wv_%0d", i), 32'(wvalid), 32'(i < 5));
         stall = 0;
         while (wvalid !== 1'b1 && stall < 100) begin
            @(negedge clk);
            #1 stall++;
         end
         check($sformatf("burst_stall_%0d", i), stall, (i == 5) ? 37 : 0);
         @(posedge clk);
         #1 idle_bus();
      end
      guard = 0;
      while (tx_busy && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check("burst_drain_timeout", 32'(guard < 500), 1);
      repeat (3) @(negedge clk);
      check("burst_frames", starts.size() - nb, 6);
      for (int i = nb + 1; i < starts.size(); i++)
         check("burst_gap", starts[i] - starts[i-1], 40);
      check("burst_q_empty", exp_q.size(), 0);
      rready = 1; raddr = STAT;
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      check("post_burst_status", rdata, 32'ha);

      // Reset mid-frame with three bytes queued
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         put(8'h55 + 8'(i * 17));
         #1 check("rq_wv", 32'(wvalid), 1);
         @(posedge clk);
         #1 idle_bus();
      end
      repeat (7) @(posedge clk);
      #2 check("pre_reset_txd", 32'(txd), 0);
      resetb = 0;
      #1 check("reset_txd", 32'(txd), 1);
      check("reset_busy", 32'(tx_busy), 0);
      check("reset_exit", 32'(exit_req), 0);
      check("reset_code", exit_code, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      resetb = 1;
      nf = frames;
      rready = 1; raddr = STAT;
      @(posedge clk);
      @(negedge clk);
      idle_bus();
      check("reset_rresp", 32'(rresp), 1);
      check("reset_status", rdata, 32'h2);
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      check("reset_txd_idle", lows, 0);
      check("reset_no_frames", frames - nf, 0);
      check("final_q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
